// File: rtl/storage_pkg.sv
// ============================================================================
// Module   : storage_pkg
// Desc     : Shared definitions for the storage arbiter: FSM state encoding,
//            default RAM address/data widths and a width helper that never
//            returns zero (for ch_out / file_idx / counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package storage_pkg;

    // Access sequencer states: one RAM access in flight at a time
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int DEF_AW = 27;
    localparam int DEF_DW = 16;

    // $clog2 that yields at least 1 so a 1-entry field still has a bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/storage_arbiter_n_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Desc     : Combinational round-robin picker. Searches the request vector
//            starting one past ptr (mod NUM_CH) and returns a one-hot grant
//            plus the binary index of the winner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import storage_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]               req,
    input  logic [clog2_min1(NUM_CH)-1:0]   ptr,
    output logic [NUM_CH-1:0]               gnt,
    output logic [clog2_min1(NUM_CH)-1:0]   idx,
    output logic                            any
);

    localparam int CW = clog2_min1(NUM_CH);

    logic [CW-1:0] cand;

    // Scan farthest-to-nearest so the nearest pending port after ptr wins last
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CW'((int'(ptr) + i) % NUM_CH);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/storage_arbiter_n.sv
// ============================================================================
// Module   : storage_arbiter_n
// Desc     : Multiplexes one SD load stream and NUM_CH round-robin playback
//            read ports onto a single strobed external RAM. Tracks file start
//            addresses and reports them to the sampler controller.
// Config   : STORAGE_ARB_STARVE_GUARD_EN - after SD_BURST consecutive SD
//            writes with reads pending, one read is forced through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module storage_arbiter_n
    import storage_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int RAM_WAIT  = 2,
    parameter int RAM_DEPTH = 2**AW,
    parameter int MAX_FILES = 16,
    parameter int SD_BURST  = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    // SD load stream (sd_data is a signed sample word)
    input  logic                                sd_valid,
    input  logic [DW-1:0]                       sd_data,
    input  logic                                sd_new_file,
    output logic                                sd_ready,
    // playback read ports
    input  logic [NUM_CH-1:0]                   pb_valid,
    input  logic [NUM_CH*AW-1:0]                pb_addr,
    output logic [NUM_CH-1:0]                   pb_ready,
    // file start reporting
    output logic                                update,
    output logic [AW-1:0]                       start_addr,
    output logic [clog2_min1(MAX_FILES)-1:0]    file_idx,
    // external RAM
    output logic [AW-1:0]                       ram_a,
    output logic [DW-1:0]                       ram_dq_i,
    input  logic [DW-1:0]                       ram_dq_o,
    output logic                                ram_cen,
    output logic                                ram_oen,
    output logic                                ram_wen,
    // read response
    output logic                                data_ready,
    output logic [DW-1:0]                       audio_out,
    output logic [clog2_min1(NUM_CH)-1:0]       ch_out,
    output logic                                full
);

    localparam int CW  = clog2_min1(NUM_CH);
    localparam int FW  = clog2_min1(MAX_FILES);
    localparam int FCW = clog2_min1(MAX_FILES + 1);
    localparam int WW  = clog2_min1(RAM_WAIT);
    localparam int BW  = clog2_min1(SD_BURST + 1);

    localparam logic [AW-1:0]  LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [FCW-1:0] FILE_LIM  = FCW'(MAX_FILES);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(RAM_WAIT - 1);
    localparam logic [CW-1:0]  RR_RST    = CW'(NUM_CH - 1);

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            full_q, full_d;
    logic [FCW-1:0]  file_cnt_q, file_cnt_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cur_ch_q, cur_ch_d;
    logic            cur_rd_q, cur_rd_d;
    logic [AW-1:0]   ram_a_q, ram_a_d;
    logic [DW-1:0]   ram_dq_i_q, ram_dq_i_d;
    logic            ram_cen_q, ram_cen_d;
    logic            ram_oen_q, ram_oen_d;
    logic            ram_wen_q, ram_wen_d;
    logic            update_q, update_d;
    logic [AW-1:0]   start_addr_q, start_addr_d;
    logic [FW-1:0]   file_idx_q, file_idx_d;
    logic            data_ready_q, data_ready_d;
    logic [DW-1:0]   audio_q, audio_d;
    logic [CW-1:0]   ch_out_q, ch_out_d;

    logic [NUM_CH-1:0] w_gnt;
    logic [CW-1:0]     w_gnt_idx;
    logic              w_rr_any;
    logic              w_starve;
    logic              w_sd_win;
    logic              w_rd_win;
    logic [AW-1:0]     w_pb_addr [NUM_CH];

    // Unpack the flat per-port address bus
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_addr
            assign w_pb_addr[k] = pb_addr[k*AW +: AW];
        end
    endgenerate

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr (
        .req    (pb_valid),
        .ptr    (rr_ptr_q),
        .gnt    (w_gnt),
        .idx    (w_gnt_idx),
        .any    (w_rr_any)
    );

`ifdef STORAGE_ARB_STARVE_GUARD_EN
    logic [BW-1:0] burst_q, burst_d;

    // Count back-to-back SD grants made while some read was waiting
    always_comb begin
        burst_d = burst_q;
        if (w_sd_win) begin
            burst_d = w_rr_any ? burst_q + BW'(1) : '0;
        end else if (w_rd_win) begin
            burst_d = '0;
        end
    end

    // Burst counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    assign w_starve = (burst_q == BW'(SD_BURST));
`else
    // Strict SD priority; a non-positive burst limit is never a valid setting
    assign w_starve = (SD_BURST < 1);
`endif

    // Grant decision, only meaningful while the sequencer is idle
    assign sd_ready = (state_q == ST_IDLE) && !full_q && !reset;
    assign w_sd_win = sd_valid && sd_ready && !(w_starve && w_rr_any);
    assign w_rd_win = (state_q == ST_IDLE) && !reset && w_rr_any && !w_sd_win;
    assign pb_ready = w_rd_win ? w_gnt : '0;

    // Access sequencer: next state, RAM strobes, file reporting, responses
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        wr_ptr_d     = wr_ptr_q;
        full_d       = full_q;
        file_cnt_d   = file_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        cur_ch_d     = cur_ch_q;
        cur_rd_d     = cur_rd_q;
        ram_a_d      = ram_a_q;
        ram_dq_i_d   = ram_dq_i_q;
        ram_cen_d    = ram_cen_q;
        ram_oen_d    = ram_oen_q;
        ram_wen_d    = ram_wen_q;
        update_d     = 1'b0;
        start_addr_d = start_addr_q;
        file_idx_d   = file_idx_q;
        data_ready_d = 1'b0;
        audio_d      = audio_q;
        ch_out_d     = ch_out_q;

        case (state_q)
            ST_IDLE: begin
                if (w_sd_win) begin
                    state_d    = ST_ACCESS;
                    cur_rd_d   = 1'b0;
                    ram_a_d    = wr_ptr_q;
                    ram_dq_i_d = sd_data;
                    ram_cen_d  = 1'b0;
                    ram_wen_d  = 1'b0;
                    // The last word is written once, then the pointer parks
                    if (wr_ptr_q == LAST_ADDR) begin
                        full_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                    if (sd_new_file && (file_cnt_q < FILE_LIM)) begin
                        update_d     = 1'b1;
                        start_addr_d = wr_ptr_q;
                        file_idx_d   = FW'(file_cnt_q);
                        file_cnt_d   = file_cnt_q + FCW'(1);
                    end
                end else if (w_rd_win) begin
                    state_d   = ST_ACCESS;
                    cur_rd_d  = 1'b1;
                    cur_ch_d  = w_gnt_idx;
                    rr_ptr_d  = w_gnt_idx;
                    ram_a_d   = w_pb_addr[w_gnt_idx];
                    ram_cen_d = 1'b0;
                    ram_oen_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    state_d   = ST_RESP;
                    wait_d    = '0;
                    ram_cen_d = 1'b1;
                    ram_oen_d = 1'b1;
                    ram_wen_d = 1'b1;
                    if (cur_rd_q) begin
                        data_ready_d = 1'b1;
                        audio_d      = ram_dq_o;
                        ch_out_d     = cur_ch_q;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            wr_ptr_q     <= '0;
            full_q       <= 1'b0;
            file_cnt_q   <= '0;
            rr_ptr_q     <= RR_RST;
            cur_ch_q     <= '0;
            cur_rd_q     <= 1'b0;
            ram_a_q      <= '0;
            ram_dq_i_q   <= '0;
            ram_cen_q    <= 1'b1;
            ram_oen_q    <= 1'b1;
            ram_wen_q    <= 1'b1;
            update_q     <= 1'b0;
            start_addr_q <= '0;
            file_idx_q   <= '0;
            data_ready_q <= 1'b0;
            audio_q      <= '0;
            ch_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            wr_ptr_q     <= wr_ptr_d;
            full_q       <= full_d;
            file_cnt_q   <= file_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_ch_q     <= cur_ch_d;
            cur_rd_q     <= cur_rd_d;
            ram_a_q      <= ram_a_d;
            ram_dq_i_q   <= ram_dq_i_d;
            ram_cen_q    <= ram_cen_d;
            ram_oen_q    <= ram_oen_d;
            ram_wen_q    <= ram_wen_d;
            update_q     <= update_d;
            start_addr_q <= start_addr_d;
            file_idx_q   <= file_idx_d;
            data_ready_q <= data_ready_d;
            audio_q      <= audio_d;
            ch_out_q     <= ch_out_d;
        end
    end

    assign update     = update_q;
    assign start_addr = start_addr_q;
    assign file_idx   = file_idx_q;
    assign ram_a      = ram_a_q;
    assign ram_dq_i   = ram_dq_i_q;
    assign ram_cen    = ram_cen_q;
    assign ram_oen    = ram_oen_q;
    assign ram_wen    = ram_wen_q;
    assign data_ready = data_ready_q;
    assign audio_out  = audio_q;
    assign ch_out     = ch_out_q;
    assign full       = full_q;

endmodule

`default_nettype wire

// File: tb/tb_storage_arbiter_n.sv
// ============================================================================
// Module   : tb_storage_arbiter_n
// Desc     : Directed scoreboard bench for storage_arbiter_n (4 ports,
//            6-bit addresses, 32-word RAM, RAM_WAIT=2, 16 files).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_storage_arbiter_n;

    localparam int NUM_CH = 4;
    localparam int AW     = 6;
    localparam int DW     = 16;
    localparam int DEPTH  = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                sd_valid;
    logic [DW-1:0]       sd_data;
    logic                sd_new_file;
    logic                sd_ready;
    logic [NUM_CH-1:0]   pb_valid;
    logic [NUM_CH*AW-1:0] pb_addr;
    logic [NUM_CH-1:0]   pb_ready;
    logic                update;
    logic [AW-1:0]       start_addr;
    logic [3:0]          file_idx;
    logic [AW-1:0]       ram_a;
    logic [DW-1:0]       ram_dq_i;
    logic [DW-1:0]       ram_dq_o;
    logic                ram_cen, ram_oen, ram_wen;
    logic                data_ready;
    logic [DW-1:0]       audio_out;
    logic [1:0]          ch_out;
    logic                full;

    storage_arbiter_n #(
        .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .RAM_WAIT(2),
        .RAM_DEPTH(DEPTH), .MAX_FILES(16), .SD_BURST(8)
    ) dut (
        .clk(clk), .reset(reset),
        .sd_valid(sd_valid), .sd_data(sd_data), .sd_new_file(sd_new_file),
        .sd_ready(sd_ready),
        .pb_valid(pb_valid), .pb_addr(pb_addr), .pb_ready(pb_ready),
        .update(update), .start_addr(start_addr), .file_idx(file_idx),
        .ram_a(ram_a), .ram_dq_i(ram_dq_i), .ram_dq_o(ram_dq_o),
        .ram_cen(ram_cen), .ram_oen(ram_oen), .ram_wen(ram_wen),
        .data_ready(data_ready), .audio_out(audio_out), .ch_out(ch_out),
        .full(full)
    );

    always #5 clk = ~clk;

    // RAM model: preloaded with 0xA000+addr, written on strobed cycles
    logic [DW-1:0] mem [DEPTH];
    bit            mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hA000 + 16'(i);
            mem_init <= 1'b1;
        end else if (!ram_cen && !ram_wen) begin
            mem[ram_a[4:0]] <= ram_dq_i;
        end
    end
    assign ram_dq_o = (!ram_cen && !ram_oen) ? mem[ram_a[4:0]] : 16'h0000;

    typedef struct packed { logic [1:0] ch; logic [15:0] d; } rd_t;
    typedef struct packed { logic [5:0] a;  logic [3:0] idx; } upd_t;

    logic [3:0] gq [$];
    rd_t        rq [$];
    upd_t       uq [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected grants, responses and file reports
    always @(negedge clk) begin
        if (!ram_wen && !ram_oen) chk("strobe_overlap", 32'({ram_wen, ram_oen}), 32'h3);
        if (pb_ready != '0) begin
            if (gq.size() == 0) chk("unexpected_grant", 32'(pb_ready), 32'h0);
            else chk("grant", 32'(pb_ready), 32'(gq.pop_front()));
        end
        if (data_ready) begin
            if (rq.size() == 0) chk("unexpected_data_ready", 32'(data_ready), 32'h0);
            else begin
                rd_t e;
                e = rq.pop_front();
                chk("ch_out", 32'(ch_out), 32'(e.ch));
                chk("audio_out", 32'(audio_out), 32'(e.d));
            end
        end
        if (update) begin
            if (uq.size() == 0) chk("unexpected_update", 32'(update), 32'h0);
            else begin
                upd_t u;
                u = uq.pop_front();
                chk("start_addr", 32'(start_addr), 32'(u.a));
                chk("file_idx", 32'(file_idx), 32'(u.idx));
            end
        end
    end

    // Called just after a posedge; returns just after the handshake edge
    task automatic sd_write(input logic [15:0] d, input logic nf);
        int n;
        n = 0;
        sd_valid = 1'b1; sd_data = d; sd_new_file = nf;
        @(negedge clk);
        while (!sd_ready && n < 60) begin @(negedge clk); n++; end
        if (!sd_ready) chk("sd_handshake_timeout", 32'(sd_ready), 32'h1);
        @(posedge clk); #1;
        sd_valid = 1'b0; sd_new_file = 1'b0;
    endtask

    // Hold pb_valid until the given number of grants is observed
    task automatic run_grants(input int want);
        int g, n;
        g = 0; n = 0;
        while (g < want && n < 200) begin
            @(negedge clk);
            if (pb_ready != '0) g++;
            n++;
        end
        if (g != want) chk("grant_count_timeout", 32'(g), 32'(want));
        @(posedge clk); #1;
        pb_valid = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sd_ready"},   32'(sd_ready), 32'h0);
        chk({tag, "_pb_ready"},   32'(pb_ready), 32'h0);
        chk({tag, "_strobes"},    32'({ram_cen, ram_oen, ram_wen}), 32'h7);
        chk({tag, "_ram_a"},      32'(ram_a), 32'h0);
        chk({tag, "_ram_dq_i"},   32'(ram_dq_i), 32'h0);
        chk({tag, "_update"},     32'(update), 32'h0);
        chk({tag, "_start_file"}, 32'({start_addr, file_idx}), 32'h0);
        chk({tag, "_data_ready"}, 32'(data_ready), 32'h0);
        chk({tag, "_audio_ch"},   32'({audio_out, ch_out}), 32'h0);
        chk({tag, "_full"},       32'(full), 32'h0);
    endtask

    initial begin
        int acc;
        reset = 1'b1; sd_valid = 1'b0; sd_data = '0; sd_new_file = 1'b0;
        pb_valid = '0; pb_addr = '0;

        // --- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("sd_ready_after_reset", 32'(sd_ready), 32'h1);
        @(posedge clk); #1;

        // --- single SD word, new file, exact timing
        uq.push_back('{a: 6'd0, idx: 4'd0});
        sd_write(16'h1234, 1'b1);
        @(negedge clk);
        chk("wr_t1_strobes", 32'({ram_cen, ram_oen, ram_wen}), 32'h2);
        chk("wr_t1_addr_data", 32'({ram_a, ram_dq_i}), 32'({6'd0, 16'h1234}));
        chk("wr_t1_update", 32'(update), 32'h1);
        chk("wr_t1_sd_ready", 32'(sd_ready), 32'h0);
        @(negedge clk);
        chk("wr_t2_wen", 32'(ram_wen), 32'h0);
        @(negedge clk);
        chk("wr_t3_wen", 32'(ram_wen), 32'h1);
        chk("wr_t3_sd_ready", 32'(sd_ready), 32'h0);
        @(negedge clk);
        chk("wr_t4_sd_ready", 32'(sd_ready), 32'h1);
        @(posedge clk); #1;

        // --- ports 0 and 2 continuously: grants alternate 0,2,0,2
        pb_addr[0*AW +: AW] = 6'd0;
        pb_addr[1*AW +: AW] = 6'd1;
        pb_addr[2*AW +: AW] = 6'd20;
        pb_addr[3*AW +: AW] = 6'd3;
        for (int i = 0; i < 2; i++) begin
            gq.push_back(4'b0001); rq.push_back('{ch: 2'd0, d: 16'h1234});
            gq.push_back(4'b0100); rq.push_back('{ch: 2'd2, d: 16'hA014});
        end
        pb_valid = 4'b0101;
        run_grants(4);
        repeat (8) @(posedge clk); #1;

        // --- SD and all ports valid: SD priority (or guard every 8 writes)
`ifdef STORAGE_ARB_STARVE_GUARD_EN
        gq.push_back(4'b1000); rq.push_back('{ch: 2'd3, d: 16'h5002});
        gq.push_back(4'b0001); rq.push_back('{ch: 2'd0, d: 16'h1234});
        gq.push_back(4'b0010); rq.push_back('{ch: 2'd1, d: 16'h5000});
        gq.push_back(4'b0100); rq.push_back('{ch: 2'd2, d: 16'hA014});
        gq.push_back(4'b1000); rq.push_back('{ch: 2'd3, d: 16'h5002});
`else
        gq.push_back(4'b1000); rq.push_back('{ch: 2'd3, d: 16'h5002});
        gq.push_back(4'b0001); rq.push_back('{ch: 2'd0, d: 16'h1234});
        gq.push_back(4'b0010); rq.push_back('{ch: 2'd1, d: 16'h5000});
        gq.push_back(4'b0100); rq.push_back('{ch: 2'd2, d: 16'hA014});
`endif
        pb_valid = 4'b1111;
        for (int i = 0; i < 10; i++) sd_write(16'h5000 + 16'(i), 1'b0);
`ifdef STORAGE_ARB_STARVE_GUARD_EN
        chk("starve_guard_grants_left", 32'(gq.size()), 32'd4);
`else
        chk("strict_prio_grants_left", 32'(gq.size()), 32'd4);
`endif
        run_grants(4);
        repeat (8) @(posedge clk); #1;

        // --- reset in the second ACCESS cycle of a read
        pb_addr[1*AW +: AW] = 6'd7;
        gq.push_back(4'b0010);
        pb_valid = 4'b0010;
        run_grants(1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_read_oen_low", 32'(ram_oen), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk); #1;

        // --- 17 new-file words: 16 reports, then flags ignored
        for (int i = 0; i < 16; i++) uq.push_back('{a: 6'(i), idx: 4'(i)});
        for (int i = 0; i < 17; i++) sd_write(16'h6000 + 16'(i), 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("file_reports_left", 32'(uq.size()), 32'd0);

        // --- fill to the end of RAM (addresses 17..31)
        for (int i = 0; i < 14; i++) sd_write(16'h7000 + 16'(i), 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("full_before_last", 32'(full), 32'h0);
        sd_write(16'h700E, 1'b0);
        @(negedge clk);
        chk("full_after_last", 32'(full), 32'h1);
        @(posedge clk); #1;

        // --- full: no further SD accepts, reads still served
        pb_addr[1*AW +: AW] = 6'd31;
        gq.push_back(4'b0010); rq.push_back('{ch: 2'd1, d: 16'h700E});
        sd_valid = 1'b1; sd_data = 16'hDEAD;
        pb_valid = 4'b0010;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sd_ready) acc++;
            if (pb_ready != '0) begin @(posedge clk); #1; pb_valid = '0; end
        end
        chk("accepts_when_full", 32'(acc), 32'd0);
        sd_valid = 1'b0;
        repeat (6) @(posedge clk);

        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);
        chk("update_queue_drained", 32'(uq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
